// File: rtl/mem_pkg.sv
// Shared memory-stage definitions: store type codes, byte-enable constants,
// store buffer defaults and the byte-merge helper used for load forwarding.
package mem_pkg;

  typedef enum logic [2:0] {
    ST_NONE = 3'd0,
    ST_W    = 3'd1,
    ST_H    = 3'd2,
    ST_B    = 3'd3
  } st_type_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 12;

  // Overlay the enabled byte lanes of data onto base.
  function automatic logic [31:0] merge_bytes(input logic [31:0] base,
                                              input logic [31:0] data,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = base;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/m_store_buffer_if.sv
// Store-buffer bus: M-stage store/load side plus the data-memory write port.
// The slave modport is the buffer's view; master is the pipeline/memory view.
interface m_store_buffer_if;

  logic        st_valid;
  logic [2:0]  st_type;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [31:0] st_pc;
  logic        stall;

  logic [31:0] ld_addr;
  logic [31:0] dm_rdata;
  logic [31:0] ld_word;
  logic        ld_hit;

  logic        dm_we;
  logic        dm_ready;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_pc;
  logic        empty;

  modport master (
    output st_valid, st_type, st_addr, st_data, st_pc, ld_addr, dm_rdata, dm_ready,
    input  stall, ld_word, ld_hit, dm_we, dm_addr, dm_wdata, dm_be, dm_pc, empty
  );

  modport slave (
    input  st_valid, st_type, st_addr, st_data, st_pc, ld_addr, dm_rdata, dm_ready,
    output stall, ld_word, ld_hit, dm_we, dm_addr, dm_wdata, dm_be, dm_pc, empty
  );

endinterface

// File: rtl/m_store_align.sv
// Turns a raw sw/sh/sb operand into lane-replicated write data and byte enables.
module m_store_align
  import mem_pkg::*;
(
  input  logic [2:0]  st_type,
  input  logic [1:0]  byte_off,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] data
);

  // Replicating the operand into every lane lets be alone select the target bytes.
  always_comb begin
    be   = BE_NONE;
    data = st_data;
    case (st_type)
      ST_W: be = BE_WORD;
      ST_H: begin
        be   = byte_off[1] ? BE_HALF_HI : BE_HALF_LO;
        data = {2{st_data[15:0]}};
      end
      ST_B: begin
        be   = BE_BYTE0 << byte_off;
        data = {4{st_data[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/m_store_buffer.sv
// Posted-write FIFO between EX/MEM and data memory, draining one store per cycle
// and forwarding pending bytes into same-word loads combinationally.
module m_store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW
) (
  input logic clk,
  input logic reset,
  m_store_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [AW-1:0]    ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [3:0]       ent_be   [DEPTH];
  logic [31:0]      ent_pc   [DEPTH];
  logic [DEPTH-1:0] ent_valid;

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;

  logic        full;
  logic        enq;
  logic        deq;
  logic [3:0]  st_be;
  logic [31:0] st_aligned;

  logic [PW-1:0] scan_idx;
  logic [31:0]   merged;
  logic          hit;
  logic          unused_addr_bits;

  m_store_align u_align (
    .st_type  (bus.st_type),
    .byte_off (bus.st_addr[1:0]),
    .st_data  (bus.st_data),
    .be       (st_be),
    .data     (st_aligned)
  );

  // Full stalls even when the head drains this cycle: there is no full-bypass path.
  assign full      = (count == FULL_COUNT);
  assign bus.empty = (count == '0);
  assign bus.stall = bus.st_valid && full;
  assign enq       = bus.st_valid && (bus.st_type != ST_NONE) && !full;
  assign bus.dm_we = !bus.empty;
  assign deq       = bus.dm_we && bus.dm_ready;

  assign bus.dm_addr  = {{(30-AW){1'b0}}, ent_addr[rd_ptr], 2'b00};
  assign bus.dm_wdata = ent_data[rd_ptr];
  assign bus.dm_be    = ent_be[rd_ptr];
  assign bus.dm_pc    = ent_pc[rd_ptr];

  assign unused_addr_bits = ^{bus.st_addr[31:AW+2], bus.ld_addr[31:AW+2], bus.ld_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (enq) begin
        ent_valid[wr_ptr] <= 1'b1;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (deq) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + PW'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  // Payload needs no reset; the valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[wr_ptr] <= bus.st_addr[AW+1:2];
      ent_data[wr_ptr] <= st_aligned;
      ent_be[wr_ptr]   <= st_be;
      ent_pc[wr_ptr]   <= bus.st_pc;
    end
  end

  // Oldest-to-youngest scan so the youngest matching store owns each byte.
  always_comb begin
    merged   = bus.dm_rdata;
    hit      = 1'b0;
    scan_idx = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr + PW'(i);
      if (ent_valid[scan_idx] && (ent_addr[scan_idx] == bus.ld_addr[AW+1:2])) begin
        hit    = 1'b1;
        merged = merge_bytes(merged, ent_data[scan_idx], ent_be[scan_idx]);
      end
    end
  end

  assign bus.ld_word = merged;
  assign bus.ld_hit  = hit;

endmodule

// File: tb/tb_m_store_buffer.sv
// Scoreboard bench for m_store_buffer: a queue model of accepted stores is
// compared against the DM port, stall/empty flags and load forwarding each cycle.
module tb_m_store_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [11:0] wa;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] pc;
  } sb_entry_t;

  logic clk = 1'b0;
  logic reset;

  int n_checks   = 0;
  int n_errors   = 0;
  int dut_writes = 0;
  int model_pops = 0;
  bit model_accepted = 1'b0;

  sb_entry_t   model_q[$];
  logic [31:0] dm_log[$];
  logic [31:0] next_pc = 32'h0000_1000;

  m_store_buffer_if bus();

  m_store_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic sb_entry_t model_entry(input logic [2:0] t, input logic [31:0] a,
                                            input logic [31:0] d, input logic [31:0] pc);
    sb_entry_t e;
    e.wa = a[13:2];
    e.pc = pc;
    case (t)
      3'd1: begin e.be = 4'b1111; e.data = d; end
      3'd2: begin e.be = a[1] ? 4'b1100 : 4'b0011; e.data = {2{d[15:0]}}; end
      3'd3: begin e.be = 4'b0001 << a[1:0]; e.data = {4{d[7:0]}}; end
      default: begin e.be = 4'b0000; e.data = d; end
    endcase
    return e;
  endfunction

  // Inputs only change at posedge+1, so the model is checked and advanced here.
  always @(negedge clk) begin : model_blk
    logic [31:0] w;
    logic        h;
    bit          will_enq;
    model_accepted = 1'b0;
    if (!reset) begin
      model_q.delete();
    end else begin
      checkOutput("stall", bus.stall, bus.st_valid && model_q.size() == DEPTH);
      checkOutput("empty", bus.empty, model_q.size() == 0);
      checkOutput("dm_we", bus.dm_we, model_q.size() != 0);
      if (model_q.size() != 0) begin
        checkOutput("dm_addr",  bus.dm_addr,  {18'd0, model_q[0].wa, 2'b00});
        checkOutput("dm_wdata", bus.dm_wdata, model_q[0].data);
        checkOutput("dm_be",    bus.dm_be,    model_q[0].be);
        checkOutput("dm_pc",    bus.dm_pc,    model_q[0].pc);
      end
      w = bus.dm_rdata;
      h = 1'b0;
      for (int i = 0; i < model_q.size(); i++) begin
        if (model_q[i].wa == bus.ld_addr[13:2]) begin
          h = 1'b1;
          for (int b = 0; b < 4; b++)
            if (model_q[i].be[b]) w[8*b +: 8] = model_q[i].data[8*b +: 8];
        end
      end
      checkOutput("ld_word", bus.ld_word, w);
      checkOutput("ld_hit",  bus.ld_hit,  h);
      if (bus.dm_we && bus.dm_ready) begin
        dut_writes++;
        dm_log.push_back(bus.dm_wdata);
      end
      will_enq = bus.st_valid && bus.st_type != 3'd0 && model_q.size() < DEPTH;
      if (model_q.size() != 0 && bus.dm_ready) begin
        void'(model_q.pop_front());
        model_pops++;
      end
      if (will_enq) begin
        model_q.push_back(model_entry(bus.st_type, bus.st_addr, bus.st_data, bus.st_pc));
        model_accepted = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    bus.st_valid = v;
    bus.st_type  = t;
    bus.st_addr  = a;
    bus.st_data  = d;
    bus.st_pc    = next_pc;
  endtask

  task automatic push_store(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    tick();
    applyStimulus(1'b1, t, a, d);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (model_accepted) begin
        ok = 1'b1;
        break;
      end
    end
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
    next_pc += 32'd4;
    checkOutput("store_accepted", {31'd0, ok}, 32'd1);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    bus.dm_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (model_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("drain_done", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int idx;
    reset        = 1'b0;
    bus.dm_ready = 1'b0;
    bus.ld_addr  = 32'h0;
    bus.dm_rdata = 32'h0BAD_F00D;
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
    repeat (2) tick();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_empty",   bus.empty,   32'd1);
    checkOutput("rst_dm_we",   bus.dm_we,   32'd0);
    checkOutput("rst_stall",   bus.stall,   32'd0);
    checkOutput("rst_ld_hit",  bus.ld_hit,  32'd0);
    checkOutput("rst_ld_word", bus.ld_word, 32'h0BAD_F00D);

    $display("[TB] test 1: single sw drains");
    tick();
    bus.dm_ready = 1'b1;
    push_store(3'd1, 32'h100, 32'h1234_5678);
    @(negedge clk);
    checkOutput("t1_dm_we",    bus.dm_we,    32'd1);
    checkOutput("t1_dm_addr",  bus.dm_addr,  32'h100);
    checkOutput("t1_dm_be",    bus.dm_be,    32'hF);
    checkOutput("t1_dm_wdata", bus.dm_wdata, 32'h1234_5678);
    tick();
    @(negedge clk);
    checkOutput("t1_empty", bus.empty, 32'd1);

    $display("[TB] test 2: sb + sh forwarding");
    tick();
    bus.dm_ready = 1'b0;
    push_store(3'd3, 32'h203, 32'h0000_00AB);
    push_store(3'd2, 32'h200, 32'h0000_CDEF);
    bus.ld_addr  = 32'h200;
    bus.dm_rdata = 32'h0;
    @(negedge clk);
    checkOutput("t2_ld_word", bus.ld_word, 32'hAB00_CDEF);
    checkOutput("t2_ld_hit",  bus.ld_hit,  32'd1);
    drain();

    $display("[TB] test 3: full and stall release");
    bus.dm_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_store(3'd1, 32'h400 + 32'(4*i), 32'hA0A0_0000 + 32'(i));
    tick();
    applyStimulus(1'b1, 3'd1, 32'h500, 32'h5555_5555);
    @(negedge clk);
    checkOutput("t3_stall_full", bus.stall, 32'd1);
    tick();
    bus.dm_ready = 1'b1;
    @(negedge clk);
    checkOutput("t3_stall_while_deq", bus.stall, 32'd1);
    tick();
    @(negedge clk);
    checkOutput("t3_stall_drop", bus.stall, 32'd0);
    tick();
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
    next_pc += 32'd4;
    drain();

    $display("[TB] test 4: same-word stores, youngest wins");
    bus.dm_ready = 1'b0;
    push_store(3'd1, 32'h40, 32'h1111_1111);
    push_store(3'd1, 32'h40, 32'h2222_2222);
    bus.ld_addr  = 32'h40;
    bus.dm_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checkOutput("t4_ld_word", bus.ld_word, 32'h2222_2222);
    checkOutput("t4_ld_hit",  bus.ld_hit,  32'd1);
    dm_log.delete();
    drain();
    checkOutput("t4_log_n", dm_log.size(), 32'd2);
    if (dm_log.size() == 2) begin
      checkOutput("t4_first_write",  dm_log[0], 32'h1111_1111);
      checkOutput("t4_second_write", dm_log[1], 32'h2222_2222);
    end

    $display("[TB] test 5: reset discards pending stores");
    bus.dm_ready = 1'b0;
    push_store(3'd1, 32'h100, 32'hCAFE_0001);
    push_store(3'd3, 32'h101, 32'h0000_0077);
    push_store(3'd2, 32'h102, 32'h0000_BEEF);
    reset = 1'b0;
    tick();
    reset        = 1'b1;
    bus.ld_addr  = 32'h100;
    bus.dm_rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    checkOutput("t5_empty",   bus.empty,   32'd1);
    checkOutput("t5_dm_we",   bus.dm_we,   32'd0);
    checkOutput("t5_ld_word", bus.ld_word, 32'h5A5A_5A5A);
    checkOutput("t5_ld_hit",  bus.ld_hit,  32'd0);

    $display("[TB] test 6: wrap with toggling dm_ready");
    tick();
    idx = 0;
    for (int cyc = 0; cyc < 80 && idx < 10; cyc++) begin
      bus.dm_ready = (cyc % 2) == 1;
      bus.ld_addr  = 32'h300 + 32'(4 * (cyc % 4));
      bus.dm_rdata = $urandom;
      applyStimulus(1'b1, 3'(1 + idx % 3), 32'h300 + 32'(4 * (idx % 4)) + 32'(idx % 4), $urandom);
      tick();
      if (model_accepted) begin
        idx++;
        next_pc += 32'd4;
      end
    end
    applyStimulus(1'b0, 3'd0, 32'h0, 32'h0);
    checkOutput("t6_all_enqueued", idx, 32'd10);
    drain();

    checkOutput("total_writes", dut_writes, model_pops);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
